spi_alu_slave: RTL
==================

# spi_alu_slave

Parametrised SPI-slave ALU, successor to the fixed 32-bit SPI ALU. It receives opcode, operand A and operand B serially, then shifts back the result and a 4-bit flag trailer in the same frame. SPI inputs are synchronised into the system clock domain and edge-detected, so no logic runs on `sclk`. Extra opcodes, a frame-error report and a parallel result port are provided for on-chip observers.

## Interface
- `WIDTH`, 32: operand and result width. Legal values are 8, 16, 32 and 64.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `nss` and `mosi`. Must be ≥ 2.
- `clock`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `spi_if`  spi_if.SLAVE  —  bundle carrying `sclk`, `nss`, `mosi` (inputs) and `miso` (output).
- `result`  out  WIDTH  last completed result. Reset value 0.
- `flags`  out  4  last completed flags {N,Z,C,V}. Reset value 0.
- `result_valid`  out  1  one-cycle pulse when `result`/`flags` update. Reset value 0.
- `frame_err`  out  1  one-cycle pulse on an aborted frame. Reset value 0.

## Operation
- **SPI mode and frame format**
  - SPI mode 0, MSB first.
  - Frame layout: 4-bit opcode, WIDTH-bit A, WIDTH-bit B, then the slave sends a WIDTH-bit result followed by {N,Z,C,V}.
  - Frame length: 4 + 3·WIDTH + 4 sclk cycles.
- **Opcodes**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(A), 6 SHL, 7 SHR, 8 SAR, 9 ROL, A ROR.
  - B SLT: signed, result = 1 or 0. C SLTU: unsigned, result = 1 or 0.
  - D–F are illegal: result = 0, flags = 4'b1111. N=Z=1 together is otherwise impossible, so this pattern marks illegal opcodes.
- **Arithmetic and width rules**
  - Shift and rotate amount = B[$clog2(WIDTH)-1:0].
  - C: ADD carries out bit WIDTH. SUB gives bit WIDTH of {0,A}−{0,B}, i.e. 1 on borrow. C = 0 for all other opcodes.
  - V: signed overflow for ADD and SUB only, otherwise 0.
  - N = result[WIDTH-1]. Z = (result == 0).
- **State machine**
  - IDLE → RX_OP on a synchronised `nss` falling edge only. A frame already in progress when reset releases is ignored until `nss` goes high, then low again.
  - RX_OP → RX_A after the 4th sclk rise.
  - RX_A → RX_B after WIDTH rises.
  - RX_B → EXEC after WIDTH rises.
  - EXEC (1 cycle) → TX: latches result and flags, and loads the TX shift register with {result, flags}.
  - TX: counts sclk rises. On each sclk fall that follows a counted rise, shifts left. After WIDTH+4 rises → DONE.
  - DONE: ignores sclk and waits for `nss` high → IDLE.
  - `nss` rising in RX_OP, RX_A, RX_B, EXEC or TX → IDLE with a `frame_err` pulse. `result`, `flags` and `result_valid` are not touched.
  - `nss` rising in DONE is normal completion, not an error.
- **MISO**
  - Outside TX: `miso` = 0.
  - In TX: `miso` = shift-register MSB.

## Timing
- **Input sampling**
  - All SPI inputs pass through SYNC_STAGES flops.
  - Edge detection compares the last two synchronised `sclk` samples.
  - `mosi` is sampled on the same cycle the rise is detected.
- **Clock ratio**
  - sclk high time and low time must each be ≥ SYNC_STAGES+2 clock periods.
  - Minimum clock:sclk ratio for SYNC_STAGES=2 is 8.
- **Result latency**
  - Last B rise detected in cycle D; EXEC in cycle D+1.
  - `result`, `flags` update and `result_valid`=1 in cycle D+2.
  - The TX MSB is on `miso` before the next sclk rise, guaranteed by the ratio rule.
- **Frame error latency**
  - `frame_err` asserts one cycle after the synchronised `nss` rise is detected.
- **Reset**
  - Synchronous reset in any state → IDLE next cycle.
  - All outputs return to 0, shift register and counters clear, `miso` = 0.

## Structure
- **Package `spi_alu_pkg`**
  - Opcode enum `alu_op_t` (4 bits).
  - FSM enum `spi_alu_state_t`.
  - Flag index constants FLAG_N/Z/C/V = 3/2/1/0.
  - Constant ILLEGAL_FLAGS = 4'b1111.
- **Sub-module `alu_core #(WIDTH)`**
  - Purely combinational: op, A, B → result, flags.
  - Unit-testable on its own.
- **Top level**
  - Synchronisers, edge detect, FSM, bit counter ($clog2(WIDTH+4)+1 bits) and shift register (WIDTH+4 bits).

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 → `miso` streams 0x80000000 then flags 1001 (N=1, V=1). `result_valid` pulses once.
- WIDTH=32, SUB 0x00000005 − 0x00000007 → 0xFFFFFFFE, flags 1010 (N=1, C=1 borrow).
- WIDTH=8, SAR 0x80 by B=0x03 → 0xF0, flags 1000. ROL 0x81 by B=0x09 → 0x03 (amount = 1).
- WIDTH=32, opcode 0xE, any operands → result 0, flags 1111.
- `nss` raised after 10 bits of A → `frame_err` pulses once, `result` keeps its previous value, `miso` = 0. The next full frame computes correctly.
- `reset` asserted mid-RX_B with `nss` still low → no output until `nss` high then low. The following AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000, flags 1000.

Source files
------------

// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI-slave ALU: opcodes, FSM states and flag layout.
package spi_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_SAR  = 4'h8,
    OP_ROL  = 4'h9,
    OP_ROR  = 4'hA,
    OP_SLT  = 4'hB,
    OP_SLTU = 4'hC
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_OP,
    ST_RX_A,
    ST_RX_B,
    ST_EXEC,
    ST_TX,
    ST_DONE
  } spi_alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // N and Z can never both be set by a legal operation, so all-ones marks an illegal opcode.
  localparam logic [3:0] ILLEGAL_FLAGS = 4'b1111;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= 4'hC;
  endfunction

endpackage

// File: rtl/spi_if.sv
// SPI bus bundle. Mode 0: master drives sclk/nss/mosi, slave drives miso; no handshake beyond nss framing.
interface spi_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;

  modport SLAVE  (input sclk, input nss, input mosi, output miso);
  modport MASTER (output sclk, output nss, output mosi, input miso);
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: op, A, B -> result and {N,Z,C,V}. Illegal opcodes give 0 with all flags set.
module alu_core
  import spi_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;
  logic               carry;
  logic               ovf;

  assign amt   = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // Rotates are shifts of the doubled operand; the wanted half is then picked out.
  assign rol_w = {a, a} << amt;
  assign ror_w = {a, a} >> amt;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << amt;
      OP_SHR:  result = a >> amt;
      OP_SAR:  result = $signed(a) >>> amt;
      OP_ROL:  result = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR:  result = ror_w[WIDTH-1:0];
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

  always_comb begin
    flags = ILLEGAL_FLAGS;
    if (is_legal_op(op)) begin
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/spi_alu_slave.sv
// SPI-slave ALU top: synchronises SPI inputs into the clock domain, receives op/A/B, returns result and flags.
module spi_alu_slave
  import spi_alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset,
  spi_if.SLAVE           spi_if,
  output logic [WIDTH-1:0] result,
  output logic [3:0]     flags,
  output logic           result_valid,
  output logic           frame_err,
  output spi_alu_state_t dbg_state
);

  localparam int CW  = $clog2(WIDTH + 4) + 1;
  localparam int TXW = WIDTH + 4;

  logic [SYNC_STAGES-1:0] sclk_sync, nss_sync, mosi_sync;
  logic sclk_d, nss_d;
  logic sclk_s, nss_s, mosi_s;
  logic sclk_rise, sclk_fall, nss_rise, nss_fall;

  spi_alu_state_t state, state_next;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [TXW-1:0]   tx_sr;
  logic             tx_armed;

  logic in_frame, abort, rx_shift, tx_count, tx_shift, exec_latch, cnt_last;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  // nss synchronises from 0 so a frame already low at reset release never shows a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync <= '0;
      nss_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      nss_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_if.sclk};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_if.nss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_if.mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      nss_d     <= nss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign nss_s     = nss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign nss_rise  = nss_s & ~nss_d;
  assign nss_fall  = ~nss_s & nss_d;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (nss_fall) state_next = ST_RX_OP;
      ST_RX_OP: if (abort) state_next = ST_IDLE;
                else if (rx_shift && cnt_last) state_next = ST_RX_A;
      ST_RX_A:  if (abort) state_next = ST_IDLE;
                else if (rx_shift && cnt_last) state_next = ST_RX_B;
      ST_RX_B:  if (abort) state_next = ST_IDLE;
                else if (rx_shift && cnt_last) state_next = ST_EXEC;
      ST_EXEC:  if (abort) state_next = ST_IDLE;
                else state_next = ST_TX;
      ST_TX:    if (abort) state_next = ST_IDLE;
                else if (tx_count && cnt_last) state_next = ST_DONE;
      ST_DONE:  if (nss_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // An nss rise anywhere between RX_OP and TX cancels every datapath action of that cycle.
  always_comb begin
    in_frame   = 1'b0;
    rx_shift   = 1'b0;
    tx_count   = 1'b0;
    tx_shift   = 1'b0;
    exec_latch = 1'b0;
    cnt_last   = 1'b0;
    case (state)
      ST_RX_OP: begin
        in_frame = 1'b1;
        rx_shift = sclk_rise;
        cnt_last = (bit_cnt == CW'(3));
      end
      ST_RX_A, ST_RX_B: begin
        in_frame = 1'b1;
        rx_shift = sclk_rise;
        cnt_last = (bit_cnt == CW'(WIDTH - 1));
      end
      ST_EXEC: begin
        in_frame   = 1'b1;
        exec_latch = 1'b1;
      end
      ST_TX: begin
        in_frame = 1'b1;
        tx_count = sclk_rise;
        tx_shift = sclk_fall & tx_armed;
        cnt_last = (bit_cnt == CW'(WIDTH + 3));
      end
      default: ;
    endcase
    abort = in_frame & nss_rise;
    if (abort) begin
      rx_shift   = 1'b0;
      tx_count   = 1'b0;
      tx_shift   = 1'b0;
      exec_latch = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt      <= '0;
      op_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      tx_sr        <= '0;
      tx_armed     <= 1'b0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      frame_err    <= abort;

      if (state_next != state)       bit_cnt <= '0;
      else if (rx_shift || tx_count) bit_cnt <= bit_cnt + CW'(1);

      if (rx_shift) begin
        if (state == ST_RX_OP) op_r <= {op_r[2:0], mosi_s};
        if (state == ST_RX_A)  a_r  <= {a_r[WIDTH-2:0], mosi_s};
        if (state == ST_RX_B)  b_r  <= {b_r[WIDTH-2:0], mosi_s};
      end

      if (exec_latch) begin
        result       <= alu_result;
        flags        <= alu_flags;
        result_valid <= 1'b1;
        tx_sr        <= {alu_result, alu_flags};
        tx_armed     <= 1'b0;
      end else if (tx_count) begin
        tx_armed <= 1'b1;
      end else if (tx_shift) begin
        tx_sr    <= tx_sr << 1;
        tx_armed <= 1'b0;
      end
    end
  end

  assign spi_if.miso = (state == ST_TX) ? tx_sr[TXW-1] : 1'b0;
  assign dbg_state   = state;

endmodule
